// File: rtl/data_mem_bridge_pkg.sv
// Shared types for the data-memory bridge: FSM states, store-buffer entry
// layout and the word-alignment helper used on every bus address.
package mem_bridge_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = XLEN / 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DRAIN     = 3'd1,
        LOAD_REQ  = 3'd2,
        LOAD_WAIT = 3'd3,
        LOAD_DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]   adr;
        logic [XLEN-1:0]   data;
        logic [STRB_W-1:0] strb;
    } sb_entry_t;

    // Clear the byte-offset bits so the bus always sees a word address.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        word_align = a & ~XLEN'(STRB_W - 1);
    endfunction

endpackage

// File: rtl/data_mem_bridge_fifo.sv
// Store buffer: small circular FIFO of posted stores. The head entry is
// presented combinationally so it can drive the bus directly while draining.
module store_buffer_fifo
    import mem_bridge_pkg::*;
#(
    parameter int SB_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  sb_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output sb_entry_t head
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t        mem [SB_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(SB_DEPTH));
    assign empty   = (count_reg == '0);
    assign pop_ok  = pop && !empty;
    // A push into a full buffer is only safe when the head leaves the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr_reg];

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Pointer and count state; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    // Entry storage; contents need no reset because the count qualifies them.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= push_entry;
    end

endmodule

// File: rtl/data_mem_bridge.sv
// Bridge from the core's single-cycle data-memory port to a valid/ready bus.
// Stores are posted into a store buffer; loads wait for the buffer to drain,
// then issue a read and hold the core in Stall until the data returns.
module data_mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int SB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemEn,
    input  logic              WriteEn,
    input  logic [XLEN-1:0]   IEUAdr,
    input  logic [XLEN-1:0]   WriteData,
    input  logic [STRB_W-1:0] WriteByteEn,
    output logic [XLEN-1:0]   ReadData,
    output logic              Stall,
    output logic              BusReqValid,
    input  logic              BusReqReady,
    output logic              BusWrite,
    output logic [XLEN-1:0]   BusAdr,
    output logic [XLEN-1:0]   BusWData,
    output logic [STRB_W-1:0] BusStrb,
    input  logic              BusRspValid,
    input  logic [XLEN-1:0]   BusRData
);

    state_t          state_reg;
    logic [XLEN-1:0] load_adr_reg;
    logic [XLEN-1:0] read_data_reg;

    logic      is_load;
    logic      store_nz;
    logic      sb_push;
    logic      sb_pop;
    logic      sb_full;
    logic      sb_empty;
    sb_entry_t sb_head;
    sb_entry_t sb_new;
    logic      drain_active;
    logic      stall_c;
    logic      valid_c;
    logic      write_c;

    assign is_load  = MemEn && !WriteEn;
    // Zero-strobe stores are no-ops: never buffered, never stalled.
    assign store_nz = MemEn && WriteEn && (WriteByteEn != '0);

    // New stores are only taken while idle; during a load the core is frozen.
    assign sb_push      = (state_reg == IDLE) && store_nz && !sb_full;
    assign drain_active = ((state_reg == IDLE) || (state_reg == DRAIN)) && !sb_empty;
    assign sb_pop       = drain_active && BusReqReady;

    assign sb_new = '{adr: word_align(IEUAdr), data: WriteData, strb: WriteByteEn};

    store_buffer_fifo #(
        .SB_DEPTH (SB_DEPTH)
    ) u_sb (
        .clk        (clk),
        .rst_n      (reset),
        .push       (sb_push),
        .push_entry (sb_new),
        .pop        (sb_pop),
        .full       (sb_full),
        .empty      (sb_empty),
        .head       (sb_head)
    );

    // Stall: a load stalls from its first cycle; a store stalls only on a full buffer.
    always_comb begin
        stall_c = 1'b0;
        case (state_reg)
            IDLE:                      stall_c = is_load || (store_nz && sb_full);
            DRAIN, LOAD_REQ, LOAD_WAIT: stall_c = 1'b1;
            default:                   stall_c = 1'b0;
        endcase
    end

    // Bus request mux: buffered writes take priority, reads only issue once drained.
    always_comb begin
        valid_c  = 1'b0;
        write_c  = 1'b0;
        BusAdr   = sb_head.adr;
        BusWData = sb_head.data;
        BusStrb  = sb_head.strb;
        if (drain_active) begin
            valid_c = 1'b1;
            write_c = 1'b1;
        end else if (state_reg == LOAD_REQ) begin
            valid_c  = 1'b1;
            BusAdr   = load_adr_reg;
            BusWData = '0;
            BusStrb  = '0;
        end
    end

    // Control outputs are forced low while reset is held, even with a request present.
    assign Stall       = stall_c && reset;
    assign BusReqValid = valid_c && reset;
    assign BusWrite    = write_c && reset;
    assign ReadData    = read_data_reg;

    // Load sequencing FSM, read-address latch and read-data capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            load_adr_reg  <= '0;
            read_data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (is_load) begin
                        if (sb_empty) begin
                            load_adr_reg <= word_align(IEUAdr);
                            state_reg    <= LOAD_REQ;
                        end else begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (sb_empty) begin
                        load_adr_reg <= word_align(IEUAdr);
                        state_reg    <= LOAD_REQ;
                    end
                end
                LOAD_REQ: begin
                    if (BusReqReady) state_reg <= LOAD_WAIT;
                end
                LOAD_WAIT: begin
                    if (BusRspValid) begin
                        read_data_reg <= BusRData;
                        state_reg     <= LOAD_DONE;
                    end
                end
                LOAD_DONE: state_reg <= IDLE;
                default:   state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Bench for data_mem_bridge: a core driver, a bus agent with a transaction
// scoreboard (program-order model of bus traffic), directed vectors and
// randomized traffic.
module tb_data_mem_bridge;
    import mem_bridge_pkg::*;

    localparam int SB_DEPTH = 4;
    localparam int TMO      = 500;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              MemEn = 1'b0;
    logic              WriteEn = 1'b0;
    logic [XLEN-1:0]   IEUAdr = '0;
    logic [XLEN-1:0]   WriteData = '0;
    logic [STRB_W-1:0] WriteByteEn = '0;
    logic [XLEN-1:0]   ReadData;
    logic              Stall;
    logic              BusReqValid;
    logic              BusReqReady = 1'b0;
    logic              BusWrite;
    logic [XLEN-1:0]   BusAdr;
    logic [XLEN-1:0]   BusWData;
    logic [STRB_W-1:0] BusStrb;
    logic              BusRspValid = 1'b0;
    logic [XLEN-1:0]   BusRData = '0;

    always #5 clk = ~clk;

    data_mem_bridge #(.SB_DEPTH(SB_DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemEn       (MemEn),
        .WriteEn     (WriteEn),
        .IEUAdr      (IEUAdr),
        .WriteData   (WriteData),
        .WriteByteEn (WriteByteEn),
        .ReadData    (ReadData),
        .Stall       (Stall),
        .BusReqValid (BusReqValid),
        .BusReqReady (BusReqReady),
        .BusWrite    (BusWrite),
        .BusAdr      (BusAdr),
        .BusWData    (BusWData),
        .BusStrb     (BusStrb),
        .BusRspValid (BusRspValid),
        .BusRData    (BusRData)
    );

    typedef struct {
        logic        w;
        logic [31:0] adr;
        logic [31:0] data;
        logic [3:0]  strb;
    } txn_t;

    typedef struct {
        bit          is_load;
        logic [31:0] adr;
        logic [31:0] data;      // store data, or read data returned for a load
        logic [3:0]  strb;
        int          delay;     // response delay for loads
        int          exp_stall;
        logic        exp_valid; // store: bus write visible the cycle after acceptance
        logic [31:0] exp_adr;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    txn_t        exp_q[$];
    int          hs_count = 0;
    int          ready_mode = 1;   // 0 low, 1 high, 2 random
    int          rsp_delay = 0;
    bit          spurious_en = 0;
    bit          force_rdata_en = 1;
    logic [31:0] force_rdata = '0;
    logic [31:0] last_rsp_data = '0;
    bit          rd_pending = 0;
    int          rd_cnt = 0;
    bit          prev_hold = 0;
    txn_t        prev_txn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Bus agent: drives Ready/response on the falling edge, then records the
    // handshake that the next rising edge will complete.
    always @(negedge clk) begin
        case (ready_mode)
            0:       BusReqReady = 1'b0;
            1:       BusReqReady = 1'b1;
            default: BusReqReady = (($urandom % 4) != 0);
        endcase
        BusRspValid = 1'b0;
        BusRData    = $urandom;
        if (rd_pending) begin
            if (rd_cnt == 0) begin
                rd_pending    = 0;
                BusRspValid   = 1'b1;
                BusRData      = force_rdata_en ? force_rdata : $urandom;
                last_rsp_data = BusRData;
            end else begin
                rd_cnt--;
            end
        end else if (spurious_en && (($urandom % 5) == 0)) begin
            BusRspValid = 1'b1;
        end
        #1;
        if (reset) begin
            if (prev_hold) begin
                checks++;
                if (!BusReqValid || BusWrite !== prev_txn.w || BusAdr !== prev_txn.adr ||
                    (prev_txn.w && (BusWData !== prev_txn.data || BusStrb !== prev_txn.strb))) begin
                    errors++;
                    $display("FAIL bus_hold actual v=%0d w=%0d adr=%h required v=1 w=%0d adr=%h",
                             BusReqValid, BusWrite, BusAdr, prev_txn.w, prev_txn.adr);
                end
            end
            if (BusReqValid && BusReqReady) begin
                hs_count++;
                prev_hold = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_txn actual w=%0d adr=%h unexpected required none", BusWrite, BusAdr);
                end else begin
                    txn_t e;
                    e = exp_q.pop_front();
                    if (BusWrite !== e.w || BusAdr !== e.adr ||
                        (e.w && (BusWData !== e.data || BusStrb !== e.strb))) begin
                        errors++;
                        $display("FAIL bus_txn actual w=%0d adr=%h data=%h strb=%h required w=%0d adr=%h data=%h strb=%h",
                                 BusWrite, BusAdr, BusWData, BusStrb, e.w, e.adr, e.data, e.strb);
                    end
                    if (!BusWrite) begin
                        rd_pending = 1;
                        rd_cnt     = rsp_delay;
                    end
                end
            end else begin
                prev_hold    = BusReqValid;
                prev_txn.w    = BusWrite;
                prev_txn.adr  = BusAdr;
                prev_txn.data = BusWData;
                prev_txn.strb = BusStrb;
            end
        end else begin
            prev_hold  = 0;
            rd_pending = 0;
        end
    end

    // Core-side store: hold the request until Stall is low at a sampling point.
    task automatic do_store(input logic [31:0] adr, input logic [31:0] data,
                            input logic [3:0] strb, output int waits);
        MemEn = 1'b1; WriteEn = 1'b1; IEUAdr = adr; WriteData = data; WriteByteEn = strb;
        waits = 0;
        while (1) begin
            @(negedge clk);
            if (!Stall || waits >= TMO) break;
            waits++;
        end
        if (waits >= TMO) begin
            checks++; errors++;
            $display("FAIL store_timeout actual=stalled required=accepted adr=%h", adr);
        end else if (strb != 0) begin
            exp_q.push_back('{1'b1, adr & ~32'h3, data, strb});
        end
        @(posedge clk); #1;
        MemEn = 1'b0; WriteEn = 1'b0;
    endtask

    // Core-side load: count stalled cycles, check data in the cycle Stall drops.
    task automatic do_load(input logic [31:0] adr, output int stalls);
        MemEn = 1'b1; WriteEn = 1'b0; IEUAdr = adr;
        exp_q.push_back('{1'b0, adr & ~32'h3, 32'h0, 4'h0});
        stalls = 0;
        while (1) begin
            @(negedge clk);
            if (!Stall || stalls >= TMO) break;
            stalls++;
        end
        if (stalls >= TMO) begin
            checks++; errors++;
            $display("FAIL load_timeout actual=stalled required=done adr=%h", adr);
        end else begin
            chk("load_rdata", ReadData, last_rsp_data);
        end
        @(posedge clk); #1;
        MemEn = 1'b0;
    endtask

    task automatic drain_wait();
        int cyc = 0;
        while ((exp_q.size() != 0 || BusReqValid) && cyc < TMO) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= TMO) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   n;
        int   hs_before;

        vecs[0] = '{0, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 0, 0, 1'b1, 32'h0000_0104};
        vecs[1] = '{0, 32'h0000_0103, 32'hAA00_0000, 4'h8, 0, 0, 1'b1, 32'h0000_0100};
        vecs[2] = '{0, 32'h0000_0200, 32'h0000_0055, 4'h0, 0, 0, 1'b0, 32'h0};
        vecs[3] = '{1, 32'h0000_0010, 32'h1234_5678, 4'h0, 0, 3, 1'b0, 32'h0};
        vecs[4] = '{1, 32'h0000_0022, 32'hCAFE_F00D, 4'h0, 2, 5, 1'b0, 32'h0};
        vecs[5] = '{0, 32'h0000_03FE, 32'hBEEF_0000, 4'hC, 0, 0, 1'b1, 32'h0000_03FC};

        // Reset state, with a load request present while reset is held.
        MemEn = 1'b1; WriteEn = 1'b0; IEUAdr = 32'h80;
        repeat (3) @(negedge clk);
        chk("rst_stall", Stall, 0);
        chk("rst_valid", BusReqValid, 0);
        chk("rst_write", BusWrite, 0);
        chk("rst_rdata", ReadData, 0);
        MemEn = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // Directed single-operation vectors from an empty buffer.
        ready_mode = 1;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_load) begin
                force_rdata = vecs[i].data;
                rsp_delay   = vecs[i].delay;
                do_load(vecs[i].adr, n);
                chk($sformatf("v%0d_stall", i), n, vecs[i].exp_stall);
                chk($sformatf("v%0d_rdata", i), ReadData, vecs[i].data);
            end else begin
                do_store(vecs[i].adr, vecs[i].data, vecs[i].strb, n);
                chk($sformatf("v%0d_stall", i), n, vecs[i].exp_stall);
                @(negedge clk);
                chk($sformatf("v%0d_valid", i), BusReqValid, vecs[i].exp_valid);
                if (vecs[i].exp_valid) begin
                    chk($sformatf("v%0d_bwrite", i), BusWrite, 1);
                    chk($sformatf("v%0d_badr", i), BusAdr, vecs[i].exp_adr);
                    chk($sformatf("v%0d_bstrb", i), BusStrb, vecs[i].strb);
                    chk($sformatf("v%0d_bwdata", i), BusWData, vecs[i].data);
                end
                @(posedge clk); #1;
            end
            drain_wait();
            $display("vector %0d done is_load=%0d adr=%h", i, vecs[i].is_load, vecs[i].adr);
        end

        // Fill the buffer with Ready low; the fifth store must wait for one pop.
        ready_mode = 0;
        @(posedge clk); #1;
        for (int i = 0; i < SB_DEPTH; i++) begin
            do_store(32'h400 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF, n);
            chk("fill_stall", n, 0);
        end
        MemEn = 1'b1; WriteEn = 1'b1; IEUAdr = 32'h410; WriteData = 32'h1004; WriteByteEn = 4'hF;
        hs_before = hs_count;
        repeat (3) begin
            @(negedge clk);
            chk("full_stall", Stall, 1);
        end
        chk("full_no_drain", hs_count, hs_before);
        @(posedge clk); #1;
        ready_mode = 1;
        do_store(32'h410, 32'h1004, 4'hF, n);
        chk("fifth_waits", n, 1);
        drain_wait();
        $display("full-buffer sequence done");

        // Two buffered stores, then a load: writes must precede the read.
        ready_mode = 0;
        @(posedge clk); #1;
        do_store(32'h500, 32'hA5A5_0001, 4'hF, n);
        do_store(32'h504, 32'hA5A5_0002, 4'h3, n);
        ready_mode = 1; rsp_delay = 2; force_rdata = 32'h0BAD_C0DE;
        do_load(32'h200, n);
        chk("drain_then_load", (n >= 6) ? 1 : 0, 1);
        chk("drain_load_rdata", ReadData, 32'h0BAD_C0DE);
        drain_wait();
        $display("store-load ordering sequence done stalls=%0d", n);

        // Reset while draining toward a load with two stores queued.
        ready_mode = 0;
        @(posedge clk); #1;
        do_store(32'h600, 32'h1111_1111, 4'hF, n);
        do_store(32'h604, 32'h2222_2222, 4'hF, n);
        MemEn = 1'b1; WriteEn = 1'b0; IEUAdr = 32'h300;
        @(negedge clk);
        chk("pre_rst_stall", Stall, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_stall", Stall, 0);
        chk("mid_rst_valid", BusReqValid, 0);
        chk("mid_rst_write", BusWrite, 0);
        chk("mid_rst_rdata", ReadData, 0);
        MemEn = 1'b0;
        exp_q.delete();
        ready_mode = 1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        hs_before = hs_count;
        repeat (6) @(negedge clk);
        chk("no_stale_writes", hs_count, hs_before);
        chk("post_rst_valid", BusReqValid, 0);
        @(posedge clk); #1;

        // Reset during LOAD_WAIT abandons the read; the next load works normally.
        rsp_delay = 30;
        MemEn = 1'b1; WriteEn = 1'b0; IEUAdr = 32'h40;
        exp_q.push_back('{1'b0, 32'h40, 32'h0, 4'h0});
        repeat (3) @(negedge clk);
        chk("wait_stall", Stall, 1);
        #2 reset = 1'b0;
        #1;
        chk("wait_rst_stall", Stall, 0);
        chk("wait_rst_valid", BusReqValid, 0);
        MemEn = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        rsp_delay = 0; force_rdata = 32'h600D_F00D;
        do_load(32'h44, n);
        chk("recover_stall", n, 3);
        chk("recover_rdata", ReadData, 32'h600D_F00D);
        $display("reset sequences done");

        // Randomized traffic against the program-order bus model.
        ready_mode = 2; spurious_en = 1; force_rdata_en = 0;
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom % 10);
            rsp_delay = int'($urandom % 4);
            if (r < 4) begin
                do_load($urandom & 32'hFFFF, n);
                $display("rand %0d load stalls=%0d rdata=%h", i, n, ReadData);
            end else begin
                logic [3:0] s;
                logic [31:0] a;
                logic [31:0] d;
                s = (r == 9) ? 4'h0 : 4'($urandom % 16);
                a = $urandom & 32'hFFFF;
                d = $urandom;
                do_store(a, d, s, n);
                $display("rand %0d store adr=%h strb=%h waits=%0d", i, a, s, n);
            end
        end
        drain_wait();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
